// File: rtl/inference_sequencer.sv
// ---------------------------------------------------------------------------
// inference_sequencer
//   Schedules one MNIST inference pass: loads the image, runs each dense
//   layer in order and takes the argmax of the output-layer class scores.
//
// Ports
//   s_axi_aclk, s_axi_areset     clock, synchronous active-high reset
//   start                        level input; a rising edge launches a pass
//   loader_start                 one-cycle pulse to the image loader
//   pix_tvalid, pix_tready       monitor taps of the loader x stream
//   layer_start[N_LAYERS]        one-hot one-cycle start pulse per layer
//   layer_done[N_LAYERS]         per-layer completion (pulse or level)
//   score_tdata/tvalid/tlast     signed class scores from the last layer
//   score_tready                 high only while the argmax is running
//   busy, done, error, err_code  pass status (err_code: 1 load timeout,
//                                2 layer timeout, 3 score framing/timeout)
//   class_id, class_valid        predicted class, valid from done until the
//                                next accepted start
//   pixel_count                  accepted pixel beats in the current pass
//   dbg_state                    current FSM state (state_t encoding)
//
// Handshake: a beat transfers on a rising clock edge where valid and ready
// are both high; score_tready depends only on the state, so scores offered
// before the argmax phase are held off rather than lost.
// ---------------------------------------------------------------------------
module inference_sequencer #(
    parameter int N_PIXELS  = 784,
    parameter int N_LAYERS  = 2,
    parameter int N_CLASSES = 10,
    parameter int SCORE_W   = 32,
    parameter int CLASS_W   = 4,
    parameter int TIMEOUT   = 1000000
) (
    input  logic                s_axi_aclk,
    input  logic                s_axi_areset,
    input  logic                start,
    output logic                loader_start,
    input  logic                pix_tvalid,
    input  logic                pix_tready,
    output logic [N_LAYERS-1:0] layer_start,
    input  logic [N_LAYERS-1:0] layer_done,
    input  logic [SCORE_W-1:0]  score_tdata,
    input  logic                score_tvalid,
    input  logic                score_tlast,
    output logic                score_tready,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [1:0]          err_code,
    output logic [CLASS_W-1:0]  class_id,
    output logic                class_valid,
    output logic [9:0]          pixel_count,
    output logic [2:0]          dbg_state
);

    localparam int TMO_W = $clog2(TIMEOUT);
    localparam int IDX_W = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1;

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_LOAD_START  = 3'd1,
        S_LOAD        = 3'd2,
        S_LAYER_START = 3'd3,
        S_LAYER_WAIT  = 3'd4,
        S_ARGMAX      = 3'd5,
        S_DONE        = 3'd6,
        S_ERROR       = 3'd7
    } state_t;

    state_t                     state_q, state_d;
    logic                       start_q;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;
    logic                       error_q, error_d;
    logic [1:0]                 err_code_q, err_code_d;
    logic [CLASS_W-1:0]         class_id_q, class_id_d;
    logic                       class_valid_q, class_valid_d;
    logic [9:0]                 pix_cnt_q, pix_cnt_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic [TMO_W-1:0]           tmo_q, tmo_d;
    logic signed [SCORE_W-1:0]  max_q, max_d;
    logic [CLASS_W-1:0]         best_q, best_d;
    logic [CLASS_W-1:0]         beat_q, beat_d;

    logic                       start_edge;
    logic                       timed_out;
    logic                       pix_beat, pix_last;
    logic                       score_beat, last_beat, take;
    logic signed [SCORE_W-1:0]  score_s;
    logic [CLASS_W-1:0]         new_best;
    logic                       fail;
    logic [1:0]                 fail_code;

    assign start_edge = start & ~start_q;
    assign timed_out  = (tmo_q == TMO_W'(TIMEOUT - 1));
    assign pix_beat   = pix_tvalid & pix_tready;
    assign pix_last   = (pix_cnt_q == 10'(N_PIXELS - 1));
    assign score_beat = score_tvalid & (state_q == S_ARGMAX);
    assign last_beat  = (beat_q == CLASS_W'(N_CLASSES - 1));
    assign score_s    = score_tdata;
    // Strict greater-than keeps the lowest index on ties.
    assign take       = (beat_q == '0) || (score_s > max_q);
    assign new_best   = take ? beat_q : best_q;

    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            state_q       <= S_IDLE;
            start_q       <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
            err_code_q    <= 2'd0;
            class_id_q    <= '0;
            class_valid_q <= 1'b0;
            pix_cnt_q     <= '0;
            idx_q         <= '0;
            tmo_q         <= '0;
            max_q         <= '0;
            best_q        <= '0;
            beat_q        <= '0;
        end else begin
            state_q       <= state_d;
            start_q       <= start;
            busy_q        <= busy_d;
            done_q        <= done_d;
            error_q       <= error_d;
            err_code_q    <= err_code_d;
            class_id_q    <= class_id_d;
            class_valid_q <= class_valid_d;
            pix_cnt_q     <= pix_cnt_d;
            idx_q         <= idx_d;
            tmo_q         <= tmo_d;
            max_q         <= max_d;
            best_q        <= best_d;
            beat_q        <= beat_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        error_d       = error_q;
        err_code_d    = err_code_q;
        class_id_d    = class_id_q;
        class_valid_d = class_valid_q;
        pix_cnt_d     = pix_cnt_q;
        idx_d         = idx_q;
        tmo_d         = tmo_q + TMO_W'(1);
        max_d         = max_q;
        best_d        = best_q;
        beat_d        = beat_q;
        fail          = 1'b0;
        fail_code     = 2'd0;

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start_edge) begin
                    state_d       = S_LOAD_START;
                    busy_d        = 1'b1;
                    error_d       = 1'b0;
                    err_code_d    = 2'd0;
                    class_valid_d = 1'b0;
                    pix_cnt_d     = '0;
                end
            end
            S_LOAD_START: begin
                state_d = S_LOAD;
                tmo_d   = '0;
            end
            S_LOAD: begin
                // Leaving LOAD on the final beat is what saturates the count.
                if (pix_beat) begin
                    pix_cnt_d = pix_cnt_q + 10'd1;
                    if (pix_last) begin
                        state_d = S_LAYER_START;
                        idx_d   = '0;
                    end
                end
                if (timed_out && !(pix_beat && pix_last)) begin
                    fail      = 1'b1;
                    fail_code = 2'd1;
                end
            end
            S_LAYER_START: begin
                state_d = S_LAYER_WAIT;
                tmo_d   = '0;
            end
            S_LAYER_WAIT: begin
                if (layer_done[idx_q]) begin
                    if (idx_q == IDX_W'(N_LAYERS - 1)) begin
                        state_d = S_ARGMAX;
                        max_d   = '0;
                        best_d  = '0;
                        beat_d  = '0;
                        tmo_d   = '0;
                    end else begin
                        state_d = S_LAYER_START;
                        idx_d   = idx_q + IDX_W'(1);
                    end
                end else if (timed_out) begin
                    fail      = 1'b1;
                    fail_code = 2'd2;
                end
            end
            S_ARGMAX: begin
                if (score_beat) begin
                    if (take) begin
                        max_d  = score_s;
                        best_d = beat_q;
                    end
                    if (score_tlast && last_beat) begin
                        state_d       = S_DONE;
                        done_d        = 1'b1;
                        busy_d        = 1'b0;
                        class_valid_d = 1'b1;
                        class_id_d    = new_best;
                    end else if (score_tlast || last_beat) begin
                        fail      = 1'b1;
                        fail_code = 2'd3;
                    end else begin
                        beat_d = beat_q + CLASS_W'(1);
                    end
                end
                if (timed_out && !(score_beat && score_tlast && last_beat)) begin
                    fail      = 1'b1;
                    fail_code = 2'd3;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (fail) begin
            state_d       = S_ERROR;
            error_d       = 1'b1;
            err_code_d    = fail_code;
            busy_d        = 1'b0;
            class_valid_d = 1'b0;
        end
    end

    assign loader_start = (state_q == S_LOAD_START);
    assign layer_start  = (state_q == S_LAYER_START) ? (N_LAYERS'(1) << idx_q) : '0;
    assign score_tready = (state_q == S_ARGMAX);
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;
    assign err_code     = err_code_q;
    assign class_id     = class_id_q;
    assign class_valid  = class_valid_q;
    assign pixel_count  = pix_cnt_q;
    assign dbg_state    = state_q;

endmodule
